// File: rtl/div_pipe_8bit_pkg.sv
// Shared arithmetic-library definitions for the pipelined divider.
// Optional signed support is selected with the DIV_PIPE_SIGNED_EN macro.
package arith_pkg;

    localparam int unsigned DIV_SIZE         = 8;
    localparam int unsigned DIV_PIPE_LATENCY = DIV_SIZE + 1;

    // Payload carried from one divider stage to the next.
    typedef struct packed {
        logic                valid;
        logic                zero;
`ifdef DIV_PIPE_SIGNED_EN
        logic                sign_q;
        logic                sign_r;
`endif
        logic [DIV_SIZE-1:0] dividend;
        logic [DIV_SIZE-1:0] divisor;
        logic [DIV_SIZE:0]   prem;
        logic [DIV_SIZE-1:0] quot;
    } div_stage_t;

    // One radix-2 restoring iteration: bring in the next dividend bit,
    // subtract the divisor when it fits, and record the quotient bit.
    function automatic div_stage_t div_step(input div_stage_t s);
        div_stage_t        n;
        logic [DIV_SIZE:0] t;
        logic              qbit;
        n = s;
        t = {s.prem[DIV_SIZE-1:0], s.dividend[DIV_SIZE-1]};
        if (t >= {1'b0, s.divisor}) begin
            n.prem = t - {1'b0, s.divisor};
            qbit   = 1'b1;
        end else begin
            n.prem = t;
            qbit   = 1'b0;
        end
        n.dividend = {s.dividend[DIV_SIZE-2:0], 1'b0};
        n.quot     = {s.quot[DIV_SIZE-2:0], qbit};
        return n;
    endfunction

endpackage

// File: rtl/div_pipe_8bit_if.sv
// Operand/result bundle for div_pipe_8bit.
// div_signed exists only when DIV_PIPE_SIGNED_EN is defined.
interface div_pipe_8bit_if #(
    parameter int unsigned size = 8
);

    logic            div_en_in;
    logic [size-1:0] div_a;
    logic [size-1:0] div_b;
`ifdef DIV_PIPE_SIGNED_EN
    logic            div_signed;
`endif
    logic            div_en_out;
    logic [size-1:0] div_q;
    logic [size-1:0] div_r;
    logic            div_zero;

    modport master (
        output div_en_in, div_a, div_b,
`ifdef DIV_PIPE_SIGNED_EN
        output div_signed,
`endif
        input  div_en_out, div_q, div_r, div_zero
    );

    modport slave (
        input  div_en_in, div_a, div_b,
`ifdef DIV_PIPE_SIGNED_EN
        input  div_signed,
`endif
        output div_en_out, div_q, div_r, div_zero
    );

endinterface

// File: rtl/div_pipe_8bit_stage.sv
// One restoring-division iteration followed by its pipeline register.
module div_pipe_stage
    import arith_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  div_stage_t i_stg,
    output div_stage_t o_stg
);

    div_stage_t w_next;
    div_stage_t r_stg;

    // Combinational iteration on the incoming payload.
    always_comb begin
        w_next = div_step(i_stg);
    end

    // Pipeline register: only the valid bit is reset, the payload just follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg.valid <= 1'b0;
        end else begin
            r_stg <= w_next;
        end
    end

    assign o_stg = r_stg;

endmodule

// File: rtl/div_pipe_8bit.sv
// Fully pipelined unsigned restoring divider: one operation per clock,
// results size+1 cycles after the operands are sampled.
// Define DIV_PIPE_SIGNED_EN to add two's-complement operation via div_signed.
module div_pipe_8bit
    import arith_pkg::*;
#(
    parameter int unsigned size = DIV_SIZE
) (
    input logic            clk,
    input logic            rst_n,
    div_pipe_8bit_if.slave bus
);

    div_stage_t      w_stg0_next;
    div_stage_t      r_stg0;
    div_stage_t      w_stg [0:size];
    logic [size-1:0] w_q_fin;
    logic [size-1:0] w_r_fin;

    logic            r_en_out;
    logic [size-1:0] r_q;
    logic [size-1:0] r_r;
    logic            r_zero;

    // Stage 0 payload: magnitudes of the operands, cleared remainder/quotient.
    always_comb begin
        w_stg0_next       = '0;
        w_stg0_next.valid = bus.div_en_in;
        w_stg0_next.zero  = (bus.div_b == '0);
`ifdef DIV_PIPE_SIGNED_EN
        w_stg0_next.sign_r   = bus.div_signed & bus.div_a[size-1];
        w_stg0_next.sign_q   = bus.div_signed & (bus.div_a[size-1] ^ bus.div_b[size-1]);
        w_stg0_next.dividend = (bus.div_signed && bus.div_a[size-1]) ? -bus.div_a : bus.div_a;
        w_stg0_next.divisor  = (bus.div_signed && bus.div_b[size-1]) ? -bus.div_b : bus.div_b;
`else
        w_stg0_next.dividend = bus.div_a;
        w_stg0_next.divisor  = bus.div_b;
`endif
    end

    // Input register: valid bit resets, operands follow the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg0.valid <= 1'b0;
        end else begin
            r_stg0 <= w_stg0_next;
        end
    end

    assign w_stg[0] = r_stg0;

    for (genvar k = 1; k <= size; k++) begin : g_stage
        div_pipe_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_stg (w_stg[k-1]),
            .o_stg (w_stg[k])
        );
    end

    // Final sign restore; a zero divisor keeps the all-ones quotient unsigned.
    always_comb begin
        w_q_fin = w_stg[size].quot;
        w_r_fin = w_stg[size].prem[size-1:0];
`ifdef DIV_PIPE_SIGNED_EN
        if (w_stg[size].sign_q && !w_stg[size].zero) begin
            w_q_fin = -w_stg[size].quot;
        end
        if (w_stg[size].sign_r) begin
            w_r_fin = -w_stg[size].prem[size-1:0];
        end
`endif
    end

    // Output register: strobe tracks the last valid bit, data loads only on valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_en_out <= w_stg[size].valid;
            if (w_stg[size].valid) begin
                r_q    <= w_q_fin;
                r_r    <= w_r_fin;
                r_zero <= w_stg[size].zero;
            end
        end
    end

    assign bus.div_en_out = r_en_out;
    assign bus.div_q      = r_q;
    assign bus.div_r      = r_r;
    assign bus.div_zero   = r_zero;

endmodule

// File: tb/tb_div_pipe_8bit.sv
// Self-checking bench for div_pipe_8bit: directed table, hand-written
// reset/hold sequences and randomized traffic against an arithmetic model.
module tb_div_pipe_8bit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    div_pipe_8bit_if #(.size(8)) bus ();

    div_pipe_8bit #(.size(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        z;
        bit          sgn;
        int unsigned smp;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        z;
        int unsigned gap;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc             = 0;
    int unsigned pass_cnt        = 0;
    int unsigned chk_cnt         = 0;
    int unsigned pulses          = 0;
    int unsigned expected_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                        input logic [7:0] r, input logic z, input bit sgn);
        exp_t e;
        @(negedge clk);
        bus.div_en_in = 1'b1;
        bus.div_a     = a;
        bus.div_b     = b;
`ifdef DIV_PIPE_SIGNED_EN
        bus.div_signed = sgn;
`endif
        e.a   = a;
        e.b   = b;
        e.q   = q;
        e.r   = r;
        e.z   = z;
        e.sgn = sgn;
        e.smp = cyc + 1;
        exp_q.push_back(e);
        expected_pulses++;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            bus.div_en_in = 1'b0;
            bus.div_a     = 8'($urandom);
            bus.div_b     = 8'($urandom);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (bus.div_en_out === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 32'(bus.div_en_out), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("q", 32'(bus.div_q), 32'(mon_e.q));
                chk("r", 32'(bus.div_r), 32'(mon_e.r));
                chk("zero", 32'(bus.div_zero), 32'(mon_e.z));
                chk("latency", cyc - mon_e.smp, 32'd9);
                if (!mon_e.sgn && !mon_e.z) begin
                    chk("invariant", 32'(bus.div_q) * 32'(mon_e.b) + 32'(bus.div_r), 32'(mon_e.a));
                    chk("rem_lt_div", 32'(bus.div_r < mon_e.b), 32'd1);
                end
            end
        end
    end

    vec_t       tbl [11];
    logic [7:0] ra, rb, rq, rr;
    logic       rz;

    initial begin
        tbl[0]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 0};
        tbl[1]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 0};
        tbl[2]  = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 0};
        tbl[3]  = '{8'd13,  8'd20,  8'd0,   8'd13, 1'b0, 0};
        tbl[4]  = '{8'd100, 8'd10,  8'd10,  8'd0,  1'b0, 0};
        tbl[5]  = '{8'd1,   8'd1,   8'd1,   8'd0,  1'b0, 0};
        tbl[6]  = '{8'd254, 8'd127, 8'd2,   8'd0,  1'b0, 0};
        tbl[7]  = '{8'd17,  8'd3,   8'd5,   8'd2,  1'b0, 0};
        tbl[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,  1'b0, 3};
        tbl[9]  = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 0};
        tbl[10] = '{8'd77,  8'd7,   8'd11,  8'd0,  1'b0, 12};

        bus.div_en_in = 1'b0;
        bus.div_a     = '0;
        bus.div_b     = '0;
`ifdef DIV_PIPE_SIGNED_EN
        bus.div_signed = 1'b0;
`endif

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_en_out", 32'(bus.div_en_out), 32'd0);
        chk("rst_q", 32'(bus.div_q), 32'd0);
        chk("rst_r", 32'(bus.div_r), 32'd0);
        chk("rst_zero", 32'(bus.div_zero), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single op, then outputs must hold while idle inputs carry garbage
        send(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
        idle(14);
        chk("hold_q", 32'(bus.div_q), 32'd28);
        chk("hold_r", 32'(bus.div_r), 32'd4);
        chk("hold_en", 32'(bus.div_en_out), 32'd0);

        // Directed table: back-to-back run plus divide-by-zero pair
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1'b0);
            if (tbl[i].gap != 0) idle(tbl[i].gap);
        end

        // Alternate-cycle traffic interrupted by an asynchronous reset pulse
        for (int i = 0; i < 8; i++) begin
            send(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
            idle(1);
        end
        chk("pre_rst_q", 32'(bus.div_q), 32'd28);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_en", 32'(bus.div_en_out), 32'd0);
        chk("async_rst_q", 32'(bus.div_q), 32'd0);
        chk("async_rst_r", 32'(bus.div_r), 32'd0);
        chk("async_rst_zero", 32'(bus.div_zero), 32'd0);
        expected_pulses -= exp_q.size();
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_en", 32'(bus.div_en_out), 32'd0);
        end
        send(8'd123, 8'd10, 8'd12, 8'd3, 1'b0, 1'b0);
        idle(12);

`ifdef DIV_PIPE_SIGNED_EN
        // Signed corner cases
        send(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b1);
        send(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b1);
        send(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        send(8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b1);
        idle(12);
`endif

        // Randomized traffic with gaps against plain integer division
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                ra = 8'($urandom);
                rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
                rz = (rb == 8'd0);
                rq = rz ? 8'hFF : ra / rb;
                rr = rz ? ra : ra % rb;
                send(ra, rb, rq, rr, rz, 1'b0);
            end
        end
        idle(1);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("pulse_count", pulses, expected_pulses);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
